// File: rtl/mantle_lane_permute_pipe_if.sv
// Handshake bundle for mantle_lane_permute_pipe: input beat side and output beat side.
// master = the block's environment, slave = the permuter itself.
interface mantle_lane_permute_pipe_if #(
    parameter int LANES  = 2,
    parameter int LANE_W = 8
);
    localparam int W  = LANES * LANE_W;
    localparam int RW = $clog2(LANES);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_mode;
    logic [RW-1:0] in_rot;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    modport master (
        output in_valid, in_data, in_mode, in_rot, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_rot, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mantle_lane_permute_pipe.sv
// Registered lane permuter (pass/reverse/rotate/pair-swap) behind a 2-entry skid buffer.
// Optional 16-bit output-transfer counter enabled by `define MANTLE_PERMUTE_COUNT_EN.
module mantle_lane_permute_pipe #(
    parameter int LANES  = 2,
    parameter int LANE_W = 8
) (
    input  logic CLK,
    input  logic ASYNCRESET,
    mantle_lane_permute_pipe_if.slave io,
    output logic busy
`ifdef MANTLE_PERMUTE_COUNT_EN
    ,
    output logic [15:0] xfer_count
`endif
);
    localparam int W = LANES * LANE_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] perm;
    logic         in_xfer;
    logic         out_xfer;

    // Scatter each input lane j to its destination lane k.
    always_comb begin : permute
        int k;
        int rot;
        perm = '0;
        k    = 0;
        rot  = int'(io.in_rot) % LANES;
        for (int j = 0; j < LANES; j++) begin
            case (io.in_mode)
                2'd0:    k = j;
                2'd1:    k = LANES - 1 - j;
                2'd2:    k = (j + rot) % LANES;
                default: k = ((j ^ 1) < LANES) ? (j ^ 1) : j;
            endcase
            perm[k*LANE_W +: LANE_W] = io.in_data[j*LANE_W +: LANE_W];
        end
    end

    assign in_xfer  = io.in_valid & in_ready_q;
    assign out_xfer = (state_q != EMPTY) & io.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    main_d  = perm;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = perm;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_d  = perm;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Registered ready keeps out_ready off any path to in_ready.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = (state_q != EMPTY);
    assign io.out_data  = main_q;
    assign busy         = (state_q != EMPTY);

`ifdef MANTLE_PERMUTE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'(out_xfer);
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`endif
endmodule
